cache_victim_ctrl: RTL and testbench
====================================

Name: cache_victim_ctrl

Overview:
- Per-set replacement controller that sits directly upstream of the N-way LRU tracker in the cache.
- Consumes tag-compare results and valid bits for a lookup, and on a miss picks the victim way: an invalid way first, else the LRU way.
- Runs the refill handshake toward the memory side and issues the one-hot USE/ENB update pulse that drives the LRU tracker.
- Keeps saturating hit and miss counters for performance monitoring.

Parameters:
N, 3, number of ways; also the width of every per-way vector.
CNT_W, 16, width of the hit and miss performance counters.

Ports:
CLK  in  1  single clock; all state updates on the rising edge.
RSTN  in  1  reset, asynchronous, active-low.
REQ_VALID  in  1  lookup result present; sampled only while REQ_READY=1.
REQ_READY  out  1  high only in IDLE.
HIT_VEC  in  N  tag-compare match per way; bit i = way i.
WAY_VALID  in  N  line-valid per way; bit i = way i.
LRU_IN  in  N  one-hot least-recently-used way from the LRU tracker; bit i = way i.
USE  out  N  one-hot way to mark most recently used; registered pulse.
ENB  out  1  update strobe to the LRU tracker; high exactly when USE≠0.
REFILL_REQ  out  1  refill request; held until acknowledged.
REFILL_WAY  out  N  one-hot victim way; stable while REFILL_REQ=1 and during WAIT.
REFILL_ACK  in  1  memory side accepted the request.
REFILL_DONE  in  1  refill data has been written; single-cycle pulse.
RESP_VALID  out  1  one-cycle completion pulse.
RESP_HIT  out  1  1 = hit, 0 = miss completed; qualified by RESP_VALID.
RESP_WAY  out  N  one-hot way serviced; qualified by RESP_VALID.
MULTI_HIT  out  1  sticky error flag; cleared only by reset.
HIT_CNT  out  CNT_W  saturating count of hits.
MISS_CNT  out  CNT_W  saturating count of misses.

Behaviour:
- Reset (RSTN=0), asynchronous, applies immediately:
  - state=IDLE.
  - USE, ENB, REFILL_REQ, REFILL_WAY, RESP_* , MULTI_HIT, HIT_CNT and MISS_CNT all 0.
  - REQ_READY=1.
  - Reset mid-refill abandons the transaction; REFILL_REQ drops asynchronously.
- States: IDLE, REQ, WAIT, UPDATE.
- Hit qualification: hv = HIT_VEC & WAY_VALID. Hit iff hv≠0.
- IDLE, REQ_VALID=1 and hit:
  - Next edge: USE=ENB-qualified one-hot of the lowest set bit of hv; RESP_VALID=1, RESP_HIT=1, RESP_WAY=same one-hot; HIT_CNT+1.
  - State remains IDLE. Latency is 1 cycle.
  - Back-to-back hits every cycle are supported.
- Multi-hit: hv with more than one bit set sets MULTI_HIT. The lowest-index way is used.
- IDLE, REQ_VALID=1 and miss:
  - Victim = lowest-index way with WAY_VALID=0 if any; else the lowest set bit of LRU_IN; if LRU_IN=0, way 0.
  - Victim is latched. MISS_CNT+1. Next state REQ.
- REQ: REFILL_REQ=1 and REFILL_WAY=victim.
  - On REFILL_ACK=1 go to WAIT; REFILL_REQ is 0 from the next cycle.
  - If REFILL_ACK and REFILL_DONE are high in the same cycle, go directly to UPDATE.
- WAIT: on REFILL_DONE=1 go to UPDATE. Otherwise hold, with no timeout.
- UPDATE (exactly one cycle):
  - Registered outputs in that cycle: USE=victim, ENB=1, RESP_VALID=1, RESP_HIT=0, RESP_WAY=victim.
  - Next state IDLE.
- Pulse outputs: USE, ENB and RESP_VALID are 0 in every cycle not listed above.
- Ignored inputs:
  - REFILL_ACK or REFILL_DONE outside their listed states.
  - REQ_VALID while REQ_READY=0. The requester must hold or reissue the lookup.
- Counters: saturate at 2^CNT_W−1 with no wrap. They count accepted lookups only.

Test Plan:
- Reset release, N=3, REQ_VALID=1, HIT_VEC=3'b010, WAY_VALID=3'b111 -> next cycle USE=3'b010, ENB=1, RESP_HIT=1, HIT_CNT=1, REQ_READY stays 1.
- Miss, WAY_VALID=3'b101, LRU_IN=3'b001 -> REFILL_WAY=3'b010 (invalid way wins). ACK after 3 cycles, DONE after 5 more -> one UPDATE cycle with USE=3'b010, RESP_HIT=0, MISS_CNT=1.
- Miss, WAY_VALID=3'b111, LRU_IN=3'b100 -> victim 3'b100. REFILL_REQ held through 4 cycles of ACK=0. ACK and DONE in the same cycle -> UPDATE on the next cycle.
- HIT_VEC=3'b110, WAY_VALID=3'b111 -> MULTI_HIT=1 (sticky across a later clean hit), RESP_WAY=3'b010. HIT_VEC=3'b001 with WAY_VALID=3'b110 -> treated as a miss.
- RSTN driven low during WAIT -> REFILL_REQ=0, counters=0, state IDLE immediately. DONE pulse after release -> no RESP_VALID.
- CNT_W=2, 5 consecutive hits -> HIT_CNT=3 (saturated), no wrap.

Source files
------------

// File: rtl/cache_victim_ctrl.sv
// Per-set victim selection, refill handshake and LRU update pulse for an N-way set.
// Hits respond in one cycle; misses run REQ -> WAIT -> UPDATE before the next lookup is accepted.
module cache_victim_ctrl #(
  parameter int N     = 3,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic [N-1:0]     HIT_VEC,
  input  logic [N-1:0]     WAY_VALID,
  input  logic [N-1:0]     LRU_IN,
  output logic [N-1:0]     USE,
  output logic             ENB,
  output logic             REFILL_REQ,
  output logic [N-1:0]     REFILL_WAY,
  input  logic             REFILL_ACK,
  input  logic             REFILL_DONE,
  output logic             RESP_VALID,
  output logic             RESP_HIT,
  output logic [N-1:0]     RESP_WAY,
  output logic             MULTI_HIT,
  output logic [CNT_W-1:0] HIT_CNT,
  output logic [CNT_W-1:0] MISS_CNT
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, UPDATE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t       state, state_nxt;
  logic [N-1:0] hv, hit_way, inv, inv_way, lru_way, victim_sel, victim;
  logic         accept, hit, multi;

  // x & (~x + 1) isolates the lowest set bit, giving lowest-index priority.
  always_comb begin
    hv         = HIT_VEC & WAY_VALID;
    hit_way    = hv & (~hv + N'(1));
    multi      = (hv & (hv - N'(1))) != '0;
    hit        = hv != '0;
    inv        = ~WAY_VALID;
    inv_way    = inv & (~inv + N'(1));
    lru_way    = LRU_IN & (~LRU_IN + N'(1));
    victim_sel = N'(1);
    if (inv != '0)
      victim_sel = inv_way;
    else if (LRU_IN != '0)
      victim_sel = lru_way;
    accept     = (state == IDLE) && REQ_VALID;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && !hit) state_nxt = REQ;
      REQ:     if (REFILL_ACK) state_nxt = REFILL_DONE ? UPDATE : WAIT;
      WAIT:    if (REFILL_DONE) state_nxt = UPDATE;
      UPDATE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state      <= IDLE;
      victim     <= '0;
      USE        <= '0;
      ENB        <= 1'b0;
      RESP_VALID <= 1'b0;
      RESP_HIT   <= 1'b0;
      RESP_WAY   <= '0;
      MULTI_HIT  <= 1'b0;
      HIT_CNT    <= '0;
      MISS_CNT   <= '0;
    end else begin
      state      <= state_nxt;
      USE        <= '0;
      ENB        <= 1'b0;
      RESP_VALID <= 1'b0;
      RESP_HIT   <= 1'b0;
      RESP_WAY   <= '0;
      if (accept && hit) begin
        USE        <= hit_way;
        ENB        <= 1'b1;
        RESP_VALID <= 1'b1;
        RESP_HIT   <= 1'b1;
        RESP_WAY   <= hit_way;
        if (multi) MULTI_HIT <= 1'b1;
        if (HIT_CNT != CNT_MAX) HIT_CNT <= HIT_CNT + CNT_W'(1);
      end
      if (accept && !hit) begin
        victim <= victim_sel;
        if (MISS_CNT != CNT_MAX) MISS_CNT <= MISS_CNT + CNT_W'(1);
      end
      // Only REQ/WAIT can lead into UPDATE, so this fires once per refill.
      if (state_nxt == UPDATE) begin
        USE        <= victim;
        ENB        <= 1'b1;
        RESP_VALID <= 1'b1;
        RESP_WAY   <= victim;
      end
    end
  end

  // Decoded straight from state so a reset drops the request without waiting for a clock.
  assign REQ_READY  = (state == IDLE);
  assign REFILL_REQ = (state == REQ);
  assign REFILL_WAY = ((state == REQ) || (state == WAIT)) ? victim : '0;

endmodule

// File: tb/tb_cache_victim_ctrl.sv
// Bench for cache_victim_ctrl: vector table, hand sequences for reset/saturation, random run vs. a transaction model.
module tb_cache_victim_ctrl;
  localparam int N = 3;

  logic clk, rstn, req_valid, refill_ack, refill_done;
  logic [N-1:0] hit_vec, way_valid, lru_in;

  logic req_ready, enb, refill_req, resp_valid, resp_hit, multi_hit;
  logic [N-1:0] use_q, refill_way, resp_way;
  logic [15:0] hit_cnt, miss_cnt;

  logic req_ready2, enb2, refill_req2, resp_valid2, resp_hit2, multi_hit2;
  logic [N-1:0] use_q2, refill_way2, resp_way2;
  logic [1:0] hit_cnt2, miss_cnt2;

  cache_victim_ctrl #(.N(N), .CNT_W(16)) dut (
    .CLK(clk), .RSTN(rstn), .REQ_VALID(req_valid), .REQ_READY(req_ready),
    .HIT_VEC(hit_vec), .WAY_VALID(way_valid), .LRU_IN(lru_in), .USE(use_q), .ENB(enb),
    .REFILL_REQ(refill_req), .REFILL_WAY(refill_way), .REFILL_ACK(refill_ack),
    .REFILL_DONE(refill_done), .RESP_VALID(resp_valid), .RESP_HIT(resp_hit),
    .RESP_WAY(resp_way), .MULTI_HIT(multi_hit), .HIT_CNT(hit_cnt), .MISS_CNT(miss_cnt));

  cache_victim_ctrl #(.N(N), .CNT_W(2)) dut2 (
    .CLK(clk), .RSTN(rstn), .REQ_VALID(req_valid), .REQ_READY(req_ready2),
    .HIT_VEC(hit_vec), .WAY_VALID(way_valid), .LRU_IN(lru_in), .USE(use_q2), .ENB(enb2),
    .REFILL_REQ(refill_req2), .REFILL_WAY(refill_way2), .REFILL_ACK(refill_ack),
    .REFILL_DONE(refill_done), .RESP_VALID(resp_valid2), .RESP_HIT(resp_hit2),
    .RESP_WAY(resp_way2), .MULTI_HIT(multi_hit2), .HIT_CNT(hit_cnt2), .MISS_CNT(miss_cnt2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Transaction-level model: an open miss, whether it was acknowledged, and a pending UPDATE cycle.
  bit m_open, m_acked, m_finish, e_multi;
  int m_victim, m_hits, m_misses;
  logic [N-1:0] e_use, e_rway;
  bit e_enb, e_rv, e_rhit;

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] r;
    r = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_open = 0; m_acked = 0; m_finish = 0; e_multi = 0;
    m_victim = 0; m_hits = 0; m_misses = 0;
    e_use = '0; e_rway = '0; e_enb = 0; e_rv = 0; e_rhit = 0;
  endtask

  task automatic finish_refill();
    m_open = 0; m_finish = 1;
    e_use = onehot(m_victim); e_enb = 1; e_rv = 1; e_rhit = 0; e_rway = onehot(m_victim);
  endtask

  task automatic model_step();
    logic [N-1:0] hv;
    int nbits, first;
    e_use = '0; e_rway = '0; e_enb = 0; e_rv = 0; e_rhit = 0;
    if (!rstn) begin
      model_reset();
    end else if (m_finish) begin
      m_finish = 0;
    end else if (!m_open) begin
      if (req_valid) begin
        hv = hit_vec & way_valid;
        nbits = 0; first = -1;
        for (int i = 0; i < N; i++)
          if (hv[i]) begin nbits++; if (first < 0) first = i; end
        if (nbits > 0) begin
          m_hits++;
          if (nbits > 1) e_multi = 1;
          e_use = onehot(first); e_enb = 1; e_rv = 1; e_rhit = 1; e_rway = onehot(first);
        end else begin
          m_misses++;
          first = -1;
          for (int i = 0; i < N; i++) if (!way_valid[i] && first < 0) first = i;
          for (int i = 0; i < N; i++) if (lru_in[i] && first < 0) first = i;
          if (first < 0) first = 0;
          m_victim = first; m_open = 1; m_acked = 0;
        end
      end
    end else if (!m_acked) begin
      if (refill_ack) begin
        if (refill_done) finish_refill();
        else m_acked = 1;
      end
    end else if (refill_done) begin
      finish_refill();
    end
  endtask

  task automatic compare_all();
    check("ready", req_ready, !(m_open || m_finish));
    check("refill_req", refill_req, m_open && !m_acked);
    if (m_open) check("refill_way", refill_way, onehot(m_victim));
    check("use", use_q, e_use);
    check("enb", enb, e_enb);
    check("resp_valid", resp_valid, e_rv);
    if (e_rv) begin
      check("resp_hit", resp_hit, e_rhit);
      check("resp_way", resp_way, e_rway);
      check("resp_way2", resp_way2, e_rway);
      check("resp_hit2", resp_hit2, e_rhit);
    end
    check("multi_hit", multi_hit, e_multi);
    check("hit_cnt", hit_cnt, sat(m_hits, 65535));
    check("miss_cnt", miss_cnt, sat(m_misses, 65535));
    check("ready2", req_ready2, !(m_open || m_finish));
    check("refill_req2", refill_req2, m_open && !m_acked);
    if (m_open) check("refill_way2", refill_way2, onehot(m_victim));
    check("use2", use_q2, e_use);
    check("enb2", enb2, e_enb);
    check("resp_valid2", resp_valid2, e_rv);
    check("multi_hit2", multi_hit2, e_multi);
    check("hit_cnt2", hit_cnt2, sat(m_hits, 3));
    check("miss_cnt2", miss_cnt2, sat(m_misses, 3));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic lookup(input logic [N-1:0] hv, input logic [N-1:0] wv, input logic [N-1:0] lru);
    req_valid = 1; hit_vec = hv; way_valid = wv; lru_in = lru;
    tick();
    req_valid = 0; hit_vec = '0; way_valid = '0; lru_in = '0;
  endtask

  task automatic run_refill(input int ack_wait, input int done_wait, input bit same);
    repeat (ack_wait) begin
      tick();
      check("hold_refill_req", refill_req, 1);
    end
    refill_ack = 1; refill_done = same;
    tick();
    refill_ack = 0; refill_done = 0;
    if (!same) begin
      check("wait_refill_req", refill_req, 0);
      repeat (done_wait) tick();
      refill_done = 1;
      tick();
      refill_done = 0;
    end
  endtask

  typedef struct {
    logic [N-1:0] hv, wv, lru;
    bit exp_hit;
    logic [N-1:0] exp_way;
    bit exp_multi;
    int ack_wait, done_wait;
    bit same;
  } vec_t;

  vec_t vec[9];

  initial begin
    vec[0] = '{3'b010, 3'b111, 3'b001, 1, 3'b010, 0, 0, 0, 0};
    vec[1] = '{3'b000, 3'b101, 3'b001, 0, 3'b010, 0, 3, 4, 0};
    vec[2] = '{3'b000, 3'b111, 3'b100, 0, 3'b100, 0, 4, 0, 1};
    vec[3] = '{3'b001, 3'b110, 3'b010, 0, 3'b001, 0, 0, 0, 0};
    vec[4] = '{3'b110, 3'b111, 3'b001, 1, 3'b010, 1, 0, 0, 0};
    vec[5] = '{3'b100, 3'b111, 3'b001, 1, 3'b100, 1, 0, 0, 0};
    vec[6] = '{3'b000, 3'b111, 3'b000, 0, 3'b001, 1, 1, 2, 0};
    vec[7] = '{3'b011, 3'b010, 3'b100, 1, 3'b010, 1, 0, 0, 0};
    vec[8] = '{3'b000, 3'b011, 3'b001, 0, 3'b100, 1, 0, 0, 1};

    rstn = 0; req_valid = 0; refill_ack = 0; refill_done = 0;
    hit_vec = '0; way_valid = '0; lru_in = '0;
    model_reset();
    #2;
    check("rst_ready", req_ready, 1);
    check("rst_use", use_q, 0);
    check("rst_enb", enb, 0);
    check("rst_refill_req", refill_req, 0);
    check("rst_refill_way", refill_way, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_multi", multi_hit, 0);
    check("rst_hit_cnt", hit_cnt, 0);
    check("rst_miss_cnt", miss_cnt, 0);
    @(posedge clk);
    #1 rstn = 1;

    for (int t = 0; t < 9; t++) begin
      lookup(vec[t].hv, vec[t].wv, vec[t].lru);
      if (vec[t].exp_hit) begin
        check("tbl_hit_valid", resp_valid, 1);
        check("tbl_hit_flag", resp_hit, 1);
        check("tbl_hit_use", use_q, vec[t].exp_way);
        check("tbl_hit_way", resp_way, vec[t].exp_way);
        check("tbl_hit_ready", req_ready, 1);
        check("tbl_multi", multi_hit, vec[t].exp_multi);
      end else begin
        check("tbl_miss_req", refill_req, 1);
        check("tbl_miss_victim", refill_way, vec[t].exp_way);
        check("tbl_miss_ready", req_ready, 0);
        run_refill(vec[t].ack_wait, vec[t].done_wait, vec[t].same);
        check("tbl_upd_use", use_q, vec[t].exp_way);
        check("tbl_upd_enb", enb, 1);
        check("tbl_upd_valid", resp_valid, 1);
        check("tbl_upd_hit", resp_hit, 0);
        check("tbl_upd_way", resp_way, vec[t].exp_way);
        check("tbl_upd_ready", req_ready, 0);
        tick();
        check("tbl_post_ready", req_ready, 1);
        check("tbl_post_enb", enb, 0);
      end
    end
    check("tbl_hit_total", hit_cnt, 4);
    check("tbl_miss_total", miss_cnt, 5);

    // Reset while REQ is asserted: the request must drop without a clock edge.
    lookup(3'b000, 3'b111, 3'b010);
    #3 rstn = 0;
    #1;
    check("arst_req_drop", refill_req, 0);
    check("arst_req_ready", req_ready, 1);
    model_reset();
    tick();
    rstn = 1;

    // Reset while in WAIT, then a stray DONE must not complete anything.
    lookup(3'b000, 3'b011, 3'b001);
    refill_ack = 1;
    tick();
    refill_ack = 0;
    #3 rstn = 0;
    #1;
    check("arstw_refill_req", refill_req, 0);
    check("arstw_refill_way", refill_way, 0);
    check("arstw_hit_cnt", hit_cnt, 0);
    check("arstw_miss_cnt", miss_cnt, 0);
    check("arstw_multi", multi_hit, 0);
    check("arstw_ready", req_ready, 1);
    model_reset();
    tick();
    rstn = 1;
    refill_done = 1;
    tick();
    refill_done = 0;
    check("stray_done_valid", resp_valid, 0);
    check("stray_done_ready", req_ready, 1);

    // Back-to-back hits into the 2-bit counter saturate without wrapping.
    for (int i = 1; i <= 5; i++) begin
      req_valid = 1; hit_vec = 3'b001; way_valid = 3'b111; lru_in = '0;
      tick();
      check("sat_valid", resp_valid, 1);
      check("sat_cnt2", hit_cnt2, (i > 3) ? 3 : i);
    end
    req_valid = 0;
    check("sat_cnt16", hit_cnt, 5);

    for (int c = 0; c < 3000; c++) begin
      req_valid   = ($urandom_range(0, 1) == 1);
      hit_vec     = N'($urandom_range(0, 7));
      way_valid   = N'($urandom_range(0, 7));
      lru_in      = N'($urandom_range(0, 7));
      refill_ack  = ($urandom_range(0, 2) == 0);
      refill_done = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
